// File: rtl/padovan_seq_checker.sv
// padovan_seq_checker
//
// Sink-side checker for the Padovan-style test sequence. Each valid sample is
// compared against a locally regenerated term s(n): seeds 0,1,1,2,2 and then
// s(n) = s(n-2) + s(n-3) modulo 2^W. The first mismatch is captured, matches
// are counted, and a sticky done/pass pair reports the result of a run of LEN
// terms.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clear      synchronous restart of a run; overrides in_valid
//   in_valid   in_data carries a sequence term this cycle
//   in_data    received term (W bits)
//   done       LEN terms consumed; sticky until clear/rst
//   pass       done with no mismatch
//   err        sticky mismatch flag for the current run
//   err_idx    index of the first mismatching term
//   err_exp    expected value at the first mismatch
//   err_got    received value at the first mismatch
//   match_cnt  number of matching terms in the current run
module padovan_seq_checker #(
    parameter int W    = 8,
    parameter int LEN  = 15,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            done,
    output logic            pass,
    output logic            err,
    output logic [IDXW-1:0] err_idx,
    output logic [W-1:0]    err_exp,
    output logic [W-1:0]    err_got,
    output logic [IDXW-1:0] match_cnt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    h1_q, h1_d;
    logic [W-1:0]    h2_q, h2_d;
    logic [W-1:0]    h3_q, h3_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            err_q, err_d;
    logic [IDXW-1:0] err_idx_q, err_idx_d;
    logic [W-1:0]    err_exp_q, err_exp_d;
    logic [W-1:0]    err_got_q, err_got_d;
    logic [IDXW-1:0] match_cnt_q, match_cnt_d;
    logic [W-1:0]    exp_val;

    // Seed terms s0..s4; only consulted while idx < 5.
    function automatic logic [W-1:0] seed_val(input logic [IDXW-1:0] i);
        case (i)
            IDXW'(1), IDXW'(2): return W'(1);
            IDXW'(3), IDXW'(4): return W'(2);
            default:            return '0;
        endcase
    endfunction

    always_comb begin
        // Recurrence uses s(n-2)+s(n-3); the add wraps with no carry out.
        exp_val     = (idx_q < IDXW'(5)) ? seed_val(idx_q) : W'(h2_q + h3_q);

        state_d     = state_q;
        idx_d       = idx_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        h3_d        = h3_q;
        err_d       = err_q;
        err_idx_d   = err_idx_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        match_cnt_d = match_cnt_q;

        if (clear) begin
            state_d     = S_RUN;
            idx_d       = '0;
            h1_d        = '0;
            h2_d        = '0;
            h3_d        = '0;
            err_d       = 1'b0;
            err_idx_d   = '0;
            err_exp_d   = '0;
            err_got_d   = '0;
            match_cnt_d = '0;
        end else if (state_q == S_RUN && in_valid) begin
            idx_d = idx_q + IDXW'(1);
            // History advances with the expected term, not in_data, so a
            // corrupted sample cannot poison the terms that follow it.
            h1_d  = exp_val;
            h2_d  = h1_q;
            h3_d  = h2_q;
            if (in_data == exp_val) begin
                match_cnt_d = match_cnt_q + IDXW'(1);
            end else if (!err_q) begin
                err_d     = 1'b1;
                err_idx_d = idx_q;
                err_exp_d = exp_val;
                err_got_d = in_data;
            end
            if (idx_q == IDXW'(LEN - 1)) begin
                state_d = S_DONE;
            end
        end

        done_d = (state_d == S_DONE);
        pass_d = done_d & ~err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            idx_q       <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            h3_q        <= h3_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign err       = err_q;
    assign err_idx   = err_idx_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_padovan_seq_checker.sv
// Testbench for padovan_seq_checker: directed runs against a run-level model
// that derives every output from the list of samples accepted so far.
module tb_padovan_seq_checker;

    localparam int W    = 8;
    localparam int LEN  = 15;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            done;
    logic            pass;
    logic            err;
    logic [IDXW-1:0] err_idx;
    logic [W-1:0]    err_exp;
    logic [W-1:0]    err_got;
    logic [IDXW-1:0] match_cnt;

    padovan_seq_checker #(.W(W), .LEN(LEN), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .done     (done),
        .pass     (pass),
        .err      (err),
        .err_idx  (err_idx),
        .err_exp  (err_exp),
        .err_got  (err_got),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] seq [LEN];
    logic [W-1:0] got_q [$];

    // Expected outputs derived from the accepted-sample list.
    logic         m_done, m_pass, m_err;
    int           m_idx, m_exp, m_got, m_cnt;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_eval();
        m_err = 1'b0; m_idx = 0; m_exp = 0; m_got = 0; m_cnt = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] == seq[i]) m_cnt++;
            else if (!m_err) begin
                m_err = 1'b1; m_idx = i; m_exp = seq[i]; m_got = got_q[i];
            end
        end
        m_done = (got_q.size() == LEN);
        m_pass = m_done && !m_err;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            check("done",      int'(done),      int'(m_done));
            check("pass",      int'(pass),      int'(m_pass));
            check("err",       int'(err),       int'(m_err));
            check("err_idx",   int'(err_idx),   m_idx);
            check("err_exp",   int'(err_exp),   m_exp);
            check("err_got",   int'(err_got),   m_got);
            check("match_cnt", int'(match_cnt), m_cnt);
        end
    end

    // One clock: drive inputs, let the edge sample them, update the model.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic clr);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        if (clr) got_q.delete();
        else if (v && got_q.size() < LEN) got_q.push_back(d);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0);
    endtask

    task automatic restart();
        cyc(1'b0, '0, 1'b1);
        idle();
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_done"},  int'(done),      0);
        check({tag, "_pass"},  int'(pass),      0);
        check({tag, "_err"},   int'(err),       0);
        check({tag, "_idx"},   int'(err_idx),   0);
        check({tag, "_exp"},   int'(err_exp),   0);
        check({tag, "_got"},   int'(err_got),   0);
        check({tag, "_cnt"},   int'(match_cnt), 0);
    endtask

    task automatic clean_run();
        for (int i = 0; i < LEN; i++) cyc(1'b1, seq[i], 1'b0);
        idle();
    endtask

    initial begin
        seq[0] = 0; seq[1] = 1; seq[2] = 1; seq[3] = 2; seq[4] = 2;
        for (int n = 5; n < LEN; n++) seq[n] = W'(seq[n-2] + seq[n-3]);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        outputs_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;
        idle();

        // Clean back-to-back run.
        for (int i = 0; i < LEN; i++) cyc(1'b1, seq[i], 1'b0);
        check("clean_done", int'(done), 1);
        check("clean_pass", int'(pass), 1);
        check("clean_cnt",  int'(match_cnt), 15);
        check("clean_err",  int'(err), 0);
        idle();

        // Single error: 6 instead of 5 at index 7.
        restart();
        for (int i = 0; i < LEN; i++) begin
            cyc(1'b1, (i == 7) ? 8'd6 : seq[i], 1'b0);
            if (i == 6) check("single_err_before", int'(err), 0);
            if (i == 7) begin
                check("single_err",     int'(err),     1);
                check("single_err_idx", int'(err_idx), 7);
                check("single_err_exp", int'(err_exp), 5);
                check("single_err_got", int'(err_got), 6);
            end
        end
        check("single_cnt",  int'(match_cnt), 14);
        check("single_pass", int'(pass), 0);
        check("single_done", int'(done), 1);

        // Two errors: index 3 gets 9, index 10 gets 0.
        restart();
        for (int i = 0; i < LEN; i++)
            cyc(1'b1, (i == 3) ? 8'd9 : (i == 10) ? 8'd0 : seq[i], 1'b0);
        check("multi_err_idx", int'(err_idx), 3);
        check("multi_err_exp", int'(err_exp), 2);
        check("multi_err_got", int'(err_got), 9);
        check("multi_cnt",     int'(match_cnt), 13);

        // Gaps between terms, then extra terms after done.
        restart();
        for (int i = 0; i < LEN; i++) begin
            cyc(1'b1, seq[i], 1'b0);
            repeat ($urandom_range(1, 5)) idle();
        end
        cyc(1'b1, 8'd50, 1'b0);
        cyc(1'b1, 8'd0,  1'b0);
        cyc(1'b1, 8'd65, 1'b0);
        idle();
        check("gap_pass", int'(pass), 1);
        check("gap_cnt",  int'(match_cnt), 15);

        // Clear colliding with a valid term after 6 terms.
        restart();
        for (int i = 0; i < 6; i++) cyc(1'b1, seq[i], 1'b0);
        cyc(1'b1, seq[6], 1'b1);
        outputs_zero("clear");
        idle();
        clean_run();
        check("after_clear_pass", int'(pass), 1);

        // Asynchronous reset mid-run after an error.
        restart();
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 2) ? 8'd5 : seq[i], 1'b0);
        check("pre_rst_err", int'(err), 1);
        #1;
        rst = 1'b1;
        got_q.delete();
        #1;
        outputs_zero("arst");
        #1;
        rst = 1'b0;
        clean_run();
        check("after_rst_pass", int'(pass), 1);
        check("after_rst_cnt",  int'(match_cnt), 15);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/padovan_seq_checker.md
# padovan_seq_checker

Receive-side checker for the 8-bit Padovan-style test sequence driven by the team's sequence generator. It samples a valid-qualified data stream and compares each sample with an internally regenerated expected term. It reports pass/fail, match count, and the first mismatch (index, expected and received value). It sits at the sink end of sequence-generator loopback and bring-up paths.

## Interface
- W, 8, data width; all arithmetic is modulo 2^W
- LEN, 15, number of terms per check run; legal range 5..2^IDXW-1
- IDXW, 4, width of index/count outputs
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous restart of a run; dominates in_valid
- in_valid  in  1  in_data is a sequence term this cycle
- in_data  in  W  received term
- done  out  1  LEN terms consumed; sticky until clear/rst
- pass  out  1  done and no mismatch; valid only while done=1
- err  out  1  sticky: at least one mismatch seen this run
- err_idx  out  IDXW  index of first mismatching term
- err_exp  out  W  expected value at first mismatch
- err_got  out  W  received value at first mismatch
- match_cnt  out  IDXW  number of terms that matched this run

## Operation
- Expected sequence s(n), n = 0..LEN-1:
  - Seeds: s0=0, s1=1, s2=1, s3=2, s4=2.
  - For n>=5: s(n) = s(n-2) + s(n-3), truncated to W bits.
  - For W=8, the first 15 terms are 0,1,1,2,2,3,4,5,7,9,12,16,21,28,37.
- Expected-term engine:
  - Index counter idx (IDXW bits) plus a 3-entry history h1=s(n-1), h2=s(n-2), h3=s(n-3).
  - No term memory.
  - For idx<5 the expected value comes from the seed constants; from idx>=5 it is h2+h3.
  - The history shifts on every accepted term, using the expected value, never in_data, so one bad sample does not corrupt later terms.
- FSM states:
  - RUN: accept terms.
  - DONE: terms ignored.
- Transitions:
  - rst or clear → RUN, with idx=0, err=0, match_cnt=0, done=0.
  - RUN, in_valid=1 and idx=LEN-1 → DONE.
  - DONE holds until clear.
- Per accepted term in RUN:
  - If in_data == expected, match_cnt increments.
  - Otherwise, if err=0: set err and capture err_idx=idx, err_exp and err_got.
  - Later mismatches only leave err set; the captured fields do not change.
  - idx increments on every accepted term.
- in_valid=0: no state change. Gaps of any length are legal.
- in_valid in DONE: ignored, and counters are frozen.
- clear and in_valid in the same cycle: clear wins and the sample is dropped.
- pass = done & ~err.
- Reset values: done=0, pass=0, err=0, err_idx=0, err_exp=0, err_got=0, match_cnt=0. Internal: idx=0, history=0, state RUN.
- Reset or clear mid-run aborts the run; no partial result is kept.

## Timing
- All outputs are registered and update on the rising edge that samples the term (1-cycle latency from in_valid high to visible effect).
- done rises on the edge that samples term LEN-1; pass/err are final in that same cycle.
- Throughput: one term per cycle, back-to-back, no stall or backpressure.
- clear takes effect at the next edge; a new run can accept a term on the cycle after clear deasserts.
- The adder is a single W-bit add with no carry out. The critical path is the seed mux, adder and comparator.

## Test plan
- Clean run: drive 0,1,1,2,2,3,4,5,7,9,12,16,21,28,37 back-to-back.
  - Required: done=1 and pass=1 one edge after the 15th term; match_cnt=15; err=0.
- Single error: send 6 in place of 5 at index 7.
  - Required: err=1 from the edge sampling index 7, with err_idx=7, err_exp=5, err_got=6.
  - At done: match_cnt=14, pass=0, and later terms still match.
- Multiple errors: corrupt indices 3 (send 9) and 10 (send 0).
  - Required: captured fields stay at err_idx=3, err_exp=2, err_got=9; match_cnt=13.
- Gaps and post-done: insert random 1–5 cycle in_valid=0 gaps in the clean stream, then send 3 extra terms after done.
  - Required: pass=1, match_cnt=15, and outputs unchanged by the extras.
- Clear handling:
  - Assert clear after 6 terms, with in_valid=1 on the same cycle. The dropped sample has no effect; all outputs return to reset values.
  - Then a full clean run gives pass=1.
- Async reset: pulse rst between clock edges mid-run, after an error is logged.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - The next run starts expecting s0=0.
